// File: rtl/floor_call_regfile.sv
// Per-floor elevator call register file: cab / hall-up / hall-down masks, saturating wait ages, oldest-floor report.
// Optional macro CALL_CANCEL_EN: set_type 2'b11 cancels the cab call at set_floor.
module floor_call_regfile #(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS),
  parameter int unsigned AGE_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_valid,
  input  logic [FLOOR_W-1:0]    set_floor,
  input  logic [1:0]            set_type,
  input  logic                  svc_valid,
  input  logic [FLOOR_W-1:0]    svc_floor,
  input  logic [1:0]            svc_dir,
  output logic [NUM_FLOORS-1:0] cab_calls,
  output logic [NUM_FLOORS-1:0] up_calls,
  output logic [NUM_FLOORS-1:0] down_calls,
  output logic                  any_call,
  output logic [FLOOR_W:0]      pending_cnt,
  output logic [FLOOR_W-1:0]    oldest_floor,
  output logic                  oldest_valid
);

  localparam int unsigned CNT_W = FLOOR_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NUM_FLOORS-1:0] cab_q, cab_d;
  logic [NUM_FLOORS-1:0] up_q, up_d;
  logic [NUM_FLOORS-1:0] down_q, down_d;
  logic [AGE_W-1:0]      age_q [NUM_FLOORS];
  logic [AGE_W-1:0]      age_d [NUM_FLOORS];

  // Next state: apply sets, then clears (clear wins on the same bit), then update ages.
  always_comb begin : next_state_c
    logic set_hit;
    logic svc_hit;
    logic clr_cab;
    logic pend_now;
    logic pend_next;
    cab_d  = cab_q;
    up_d   = up_q;
    down_d = down_q;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      age_d[i]  = age_q[i];
      set_hit   = set_valid && (set_floor == FLOOR_W'(i));
      svc_hit   = svc_valid && (svc_floor == FLOOR_W'(i));
      clr_cab   = svc_hit;
      pend_now  = 1'b0;
      pend_next = 1'b0;
      if (set_hit && set_type == 2'b00) cab_d[i] = 1'b1;
      if (set_hit && set_type == 2'b01 && i != NUM_FLOORS - 1) up_d[i] = 1'b1;
      if (set_hit && set_type == 2'b10 && i != 0) down_d[i] = 1'b1;
`ifdef CALL_CANCEL_EN
      if (set_hit && set_type == 2'b11) clr_cab = 1'b1;
`endif
      if (clr_cab) cab_d[i] = 1'b0;
      if (svc_hit && svc_dir != 2'b10) up_d[i] = 1'b0;
      if (svc_hit && svc_dir != 2'b01) down_d[i] = 1'b0;
      pend_now  = cab_q[i] | up_q[i] | down_q[i];
      pend_next = cab_d[i] | up_d[i] | down_d[i];
      // Age restarts whenever a floor becomes pending or goes idle.
      if (!pend_now || !pend_next) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cab_q  <= '0;
      up_q   <= '0;
      down_q <= '0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) age_q[i] <= '0;
    end else begin
      cab_q  <= cab_d;
      up_q   <= up_d;
      down_q <= down_d;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) age_q[i] <= age_d[i];
    end
  end

  assign cab_calls  = cab_q;
  assign up_calls   = up_q;
  assign down_calls = down_q;

  // Summary outputs depend only on state, so they line up with the masks.
  always_comb begin : summary_c
    logic [NUM_FLOORS-1:0] pend;
    logic [AGE_W-1:0]      best_age;
    logic                  found;
    pend         = cab_q | up_q | down_q;
    any_call     = |pend;
    oldest_valid = |pend;
    pending_cnt  = '0;
    oldest_floor = '0;
    best_age     = '0;
    found        = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      pending_cnt = pending_cnt + CNT_W'(pend[i]);
      if (pend[i] && (!found || age_q[i] > best_age)) begin
        found        = 1'b1;
        best_age     = age_q[i];
        oldest_floor = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_floor_call_regfile.sv
// Self-checking bench for floor_call_regfile: directed scenarios plus randomized traffic against a behavioural model.
module tb_floor_call_regfile;

  localparam int N       = 8;
  localparam int FW      = 3;
  localparam int AGE_MAX = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          set_valid = 1'b0;
  logic [FW-1:0] set_floor = '0;
  logic [1:0]    set_type = '0;
  logic          svc_valid = 1'b0;
  logic [FW-1:0] svc_floor = '0;
  logic [1:0]    svc_dir = '0;
  logic [N-1:0]  cab_calls, up_calls, down_calls;
  logic          any_call, oldest_valid;
  logic [FW:0]   pending_cnt;
  logic [FW-1:0] oldest_floor;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: one flag per call kind per floor plus an integer age.
  bit m_cab [N];
  bit m_up  [N];
  bit m_dn  [N];
  int m_age [N];

  floor_call_regfile dut (
    .clk(clk), .reset(reset),
    .set_valid(set_valid), .set_floor(set_floor), .set_type(set_type),
    .svc_valid(svc_valid), .svc_floor(svc_floor), .svc_dir(svc_dir),
    .cab_calls(cab_calls), .up_calls(up_calls), .down_calls(down_calls),
    .any_call(any_call), .pending_cnt(pending_cnt),
    .oldest_floor(oldest_floor), .oldest_valid(oldest_valid)
  );

  always #5 clk = ~clk;

  function automatic bit m_pend(input int f);
    return m_cab[f] || m_up[f] || m_dn[f];
  endfunction

  function automatic logic [N-1:0] m_mask(input int kind);
    logic [N-1:0] r;
    r = '0;
    for (int f = 0; f < N; f++)
      r[f] = (kind == 0) ? m_cab[f] : (kind == 1) ? m_up[f] : m_dn[f];
    return r;
  endfunction

  function automatic int m_count();
    int c;
    c = 0;
    for (int f = 0; f < N; f++) if (m_pend(f)) c++;
    return c;
  endfunction

  function automatic int m_oldest();
    int best, ba;
    best = 0;
    ba = -1;
    for (int f = 0; f < N; f++)
      if (m_pend(f) && m_age[f] > ba) begin
        ba = m_age[f];
        best = f;
      end
    return best;
  endfunction

  // Advance the model by one clock edge using the rules of the call register file.
  task automatic model_edge();
    bit was, cancel;
    for (int f = 0; f < N; f++) begin
      if (reset) begin
        m_cab[f] = 0; m_up[f] = 0; m_dn[f] = 0; m_age[f] = 0;
        continue;
      end
      was = m_pend(f);
      cancel = 0;
      if (set_valid && int'(set_floor) == f) begin
        case (set_type)
          2'b00: m_cab[f] = 1;
          2'b01: if (f != N - 1) m_up[f] = 1;
          2'b10: if (f != 0) m_dn[f] = 1;
          default: begin
`ifdef CALL_CANCEL_EN
            cancel = 1;
`endif
          end
        endcase
      end
      if (svc_valid && int'(svc_floor) == f) begin
        m_cab[f] = 0;
        if (svc_dir != 2'b10) m_up[f] = 0;
        if (svc_dir != 2'b01) m_dn[f] = 0;
      end
      if (cancel) m_cab[f] = 0;
      if (!m_pend(f) || !was) m_age[f] = 0;
      else if (m_age[f] < AGE_MAX) m_age[f]++;
    end
  endtask

  task automatic step(input bit rst, input bit sv, input int sf, input int st,
                      input bit vv, input int vf, input int vd);
    @(negedge clk);
    reset     = rst;
    set_valid = sv;
    set_floor = FW'(sf);
    set_type  = 2'(st);
    svc_valid = vv;
    svc_floor = FW'(vf);
    svc_dir   = 2'(vd);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({cab_calls, up_calls, down_calls} !== '0) begin
      n_bad++; $display("FAIL reset_masks got %h/%h/%h want 0", cab_calls, up_calls, down_calls);
    end
    n_cmp++;
    if ({any_call, pending_cnt, oldest_floor, oldest_valid} !== '0) begin
      n_bad++; $display("FAIL reset_summary any=%b cnt=%0d old=%0d ov=%b want all 0",
                        any_call, pending_cnt, oldest_floor, oldest_valid);
    end
  endtask

  task automatic test_cab_saturation();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    n_cmp++;
    if (cab_calls !== 8'h08 || any_call !== 1'b1 || pending_cnt !== 4'd1 ||
        oldest_floor !== 3'd3 || oldest_valid !== 1'b1) begin
      n_bad++; $display("FAIL cab3_set cab=%h any=%b cnt=%0d old=%0d want 08/1/1/3",
                        cab_calls, any_call, pending_cnt, oldest_floor);
    end
    idle(20);
    step(0, 1, 1, 0, 0, 0, 0);
    idle(14);
    n_cmp++;
    if (oldest_floor !== 3'd3) begin
      n_bad++; $display("FAIL age_saturate_pre got %0d want 3", oldest_floor);
    end
    idle(1);
    n_cmp++;
    if (oldest_floor !== 3'd1) begin
      n_bad++; $display("FAIL age_saturate_tie got %0d want 1", oldest_floor);
    end
  endtask

  task automatic test_hall_boundary();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 7, 1, 0, 0, 0);
    step(0, 1, 0, 2, 0, 0, 0);
    n_cmp++;
    if ({cab_calls, up_calls, down_calls} !== '0 || any_call !== 1'b0) begin
      n_bad++; $display("FAIL hall_edge_ignored up=%h dn=%h any=%b want 0", up_calls, down_calls, any_call);
    end
    step(0, 1, 6, 1, 0, 0, 0);
    step(0, 1, 1, 2, 0, 0, 0);
    n_cmp++;
    if (up_calls !== 8'h40 || down_calls !== 8'h02 || pending_cnt !== 4'd2) begin
      n_bad++; $display("FAIL hall_set up=%h dn=%h cnt=%0d want 40/02/2", up_calls, down_calls, pending_cnt);
    end
  endtask

  task automatic test_partial_clear();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0, 0);
    step(0, 1, 4, 1, 0, 0, 0);
    step(0, 1, 4, 2, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4, 1);
    n_cmp++;
    if (cab_calls !== 8'h04 || up_calls !== 8'h00 || down_calls !== 8'h10 || oldest_floor !== 3'd4) begin
      n_bad++; $display("FAIL svc_up_partial cab=%h up=%h dn=%h old=%0d want 04/00/10/4",
                        cab_calls, up_calls, down_calls, oldest_floor);
    end
    step(0, 0, 0, 0, 1, 4, 2);
    n_cmp++;
    if (down_calls !== 8'h00 || pending_cnt !== 4'd1 || oldest_floor !== 3'd2) begin
      n_bad++; $display("FAIL svc_down_full dn=%h cnt=%0d old=%0d want 00/1/2",
                        down_calls, pending_cnt, oldest_floor);
    end
  endtask

  task automatic test_clear_wins();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 1, 1, 2, 1);
    n_cmp++;
    if (up_calls !== 8'h00 || any_call !== 1'b0) begin
      n_bad++; $display("FAIL clear_wins up=%h any=%b want 00/0", up_calls, any_call);
    end
    step(0, 1, 5, 0, 1, 2, 0);
    n_cmp++;
    if (cab_calls !== 8'h20) begin
      n_bad++; $display("FAIL set_other_floor cab=%h want 20", cab_calls);
    end
  endtask

  task automatic test_oldest();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 6, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 1, 0, 0, 0, 0);
    n_cmp++;
    if (oldest_floor !== 3'd6) begin
      n_bad++; $display("FAIL oldest_6 got %0d want 6", oldest_floor);
    end
    step(0, 0, 0, 0, 1, 6, 3);
    n_cmp++;
    if (oldest_floor !== 3'd1 || cab_calls !== 8'h02) begin
      n_bad++; $display("FAIL oldest_after_clear old=%0d cab=%h want 1/02", oldest_floor, cab_calls);
    end
    step(0, 1, 5, 0, 1, 1, 0);
    step(0, 1, 2, 0, 0, 0, 0);
    idle(20);
    n_cmp++;
    if (oldest_floor !== 3'd2 || cab_calls !== 8'h24) begin
      n_bad++; $display("FAIL oldest_tie old=%0d cab=%h want 2/24", oldest_floor, cab_calls);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0, 0);
    step(0, 1, 7, 2, 0, 0, 0);
    n_cmp++;
    if (pending_cnt !== 4'd3) begin
      n_bad++; $display("FAIL pre_reset_cnt got %0d want 3", pending_cnt);
    end
    step(1, 1, 5, 0, 0, 0, 0);
    n_cmp++;
    if ({cab_calls, up_calls, down_calls, any_call, pending_cnt, oldest_floor, oldest_valid} !== '0) begin
      n_bad++; $display("FAIL reset_priority cab=%h up=%h dn=%h cnt=%0d want all 0",
                        cab_calls, up_calls, down_calls, pending_cnt);
    end
  endtask

  task automatic test_cancel();
    logic [N-1:0] want;
`ifdef CALL_CANCEL_EN
    want = 8'h00;
`else
    want = 8'h08;
`endif
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 1, 3, 3, 0, 0, 0);
    n_cmp++;
    if (cab_calls !== want) begin
      n_bad++; $display("FAIL cancel_type11 cab=%h want %h", cab_calls, want);
    end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, N - 1),
           $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, N - 1),
           $urandom_range(0, 3));
      n_cmp++;
      if (cab_calls !== m_mask(0) || up_calls !== m_mask(1) || down_calls !== m_mask(2)) begin
        n_bad++; $display("FAIL rand_masks cyc=%0d got %h/%h/%h want %h/%h/%h", i,
                          cab_calls, up_calls, down_calls, m_mask(0), m_mask(1), m_mask(2));
      end
      n_cmp++;
      if (pending_cnt !== (FW+1)'(m_count()) || any_call !== (m_count() != 0) ||
          oldest_valid !== (m_count() != 0)) begin
        n_bad++; $display("FAIL rand_count cyc=%0d cnt=%0d any=%b want %0d", i,
                          pending_cnt, any_call, m_count());
      end
      n_cmp++;
      if (oldest_floor !== FW'(m_oldest())) begin
        n_bad++; $display("FAIL rand_oldest cyc=%0d got %0d want %0d", i, oldest_floor, m_oldest());
      end
    end
  endtask

  initial begin
    for (int f = 0; f < N; f++) begin
      m_cab[f] = 0; m_up[f] = 0; m_dn[f] = 0; m_age[f] = 0;
    end
    test_reset();
    test_cab_saturation();
    test_hall_boundary();
    test_partial_clear();
    test_clear_wins();
    test_oldest();
    test_reset_mid();
    test_cancel();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
